// File: rtl/mips_pkg.sv
// Shared pipeline constants and the fetch-queue entry layout.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned FQ_DEPTH  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction queue between fetch and decode.
// Head entry is shown combinationally from registered state; no input bypass.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Flush,
  input  logic          F_Valid,
  input  logic [31:0]   F_PC,
  input  logic [31:0]   F_Instr,
  output logic          F_Ready,
  output logic          D_Valid,
  output logic [31:0]   D_PC,
  output logic [31:0]   D_Instr,
  input  logic          D_Ready,
  output logic [CW-1:0] Count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fq_entry_t     mem [DEPTH];
  fq_entry_t     head_entry;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  // Ready depends only on occupancy, so a pop never frees a slot for the same cycle.
  assign F_Ready    = (count_q != CW'(DEPTH));
  assign D_Valid    = (count_q != CW'(0));
  assign push       = F_Valid && F_Ready && !Flush;
  assign pop        = D_Valid && D_Ready && !Flush;
  assign head_entry = mem[head];
  assign D_PC       = D_Valid ? head_entry.pc    : 32'h0000_0000;
  assign D_Instr    = D_Valid ? head_entry.instr : NOP_INSTR;
  assign Count      = count_q;

  // Storage carries no reset; validity lives entirely in count_q.
  always_ff @(posedge Clk) begin
    if (push && !Reset) begin
      mem[tail] <= '{pc: F_PC, instr: F_Instr};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: accepted pushes are queued, pops compared.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          Clk = 1'b0;
  logic          Reset, Flush, F_Valid, D_Ready;
  logic [31:0]   F_PC, F_Instr;
  logic          F_Ready, D_Valid;
  logic [31:0]   D_PC, D_Instr;
  logic [CW-1:0] Count;

  logic [63:0] sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .F_Valid(F_Valid), .F_PC(F_PC), .F_Instr(F_Instr), .F_Ready(F_Ready),
    .D_Valid(D_Valid), .D_PC(D_PC), .D_Instr(D_Instr), .D_Ready(D_Ready),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check pre-edge outputs against the model, clock, update model, check Count.
  task automatic cycle();
    logic m_push, m_pop;
    logic [63:0] head;
    m_push = F_Valid && (sb_q.size() != DEPTH) && !Flush;
    m_pop  = (sb_q.size() != 0) && D_Ready && !Flush;
    if (!Reset) begin
      check("f_ready", 64'(F_Ready), 64'(sb_q.size() != DEPTH));
      check("d_valid", 64'(D_Valid), 64'(sb_q.size() != 0));
      head = (sb_q.size() != 0) ? sb_q[0] : 64'h0;
      check("d_pc",    64'(D_PC),    64'(head[63:32]));
      check("d_instr", 64'(D_Instr), 64'(head[31:0]));
    end
    @(posedge Clk);
    if (Reset || Flush) begin
      sb_q.delete();
    end else begin
      if (m_pop)  void'(sb_q.pop_front());
      if (m_push) sb_q.push_back({F_PC, F_Instr});
    end
    #1;
    check("count", 64'(Count), 64'(sb_q.size()));
  endtask

  task automatic drive(input logic rst, input logic fl, input logic fv,
                       input logic [31:0] pc, input logic dr);
    Reset   = rst;
    Flush   = fl;
    F_Valid = fv;
    F_PC    = pc;
    F_Instr = $urandom;
    D_Ready = dr;
    cycle();
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_count"},   64'(Count),   64'd0);
    check({tag, "_dvalid"},  64'(D_Valid), 64'd0);
    check({tag, "_dpc"},     64'(D_PC),    64'd0);
    check({tag, "_dinstr"},  64'(D_Instr), 64'd0);
    check({tag, "_fready"},  64'(F_Ready), 64'd1);
  endtask

  initial begin
    logic [31:0] pc;
    Reset = 1'b1; Flush = 1'b0; F_Valid = 1'b0; D_Ready = 1'b0;
    F_PC = '0; F_Instr = '0;
    #1;
    drive(1, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 32'h0, 0);
    expect_reset_outputs("reset");

    // Fill: four pushes, fifth rejected, head stays at 0x3000
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'h3000 + 32'(4 * i), 0);
    check("fill_count",  64'(Count),   64'd4);
    check("fill_fready", 64'(F_Ready), 64'd0);
    drive(0, 0, 1, 32'h3010, 0);
    check("fill_head", 64'(D_PC), 64'h3000);
    check("fill_count5", 64'(Count), 64'd4);

    // Drain
    for (int i = 0; i < 4; i++) begin
      check("drain_seq", 64'(D_PC), 64'(32'h3000 + 32'(4 * i)));
      drive(0, 0, 0, 32'h0, 1);
    end
    expect_reset_outputs("drained");

    // Streaming from empty
    pc = 32'h4000;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, pc, 1);
      check("stream_pc", 64'(D_PC), 64'(pc));
      pc += 32'd4;
    end
    check("stream_count", 64'(Count), 64'd1);
    drive(0, 0, 0, 32'h0, 1);

    // Flush with Count=3 together with push and pop
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 32'h5000 + 32'(4 * i), 0);
    check("pre_flush_count", 64'(Count), 64'd3);
    drive(0, 1, 1, 32'h5100, 1);
    check("flush_count",  64'(Count),   64'd0);
    check("flush_dvalid", 64'(D_Valid), 64'd0);
    drive(0, 0, 0, 32'h0, 1);

    // Full queue: pop with concurrent push, push must be refused
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'h6000 + 32'(4 * i), 0);
    drive(0, 0, 1, 32'hDEAD_0000, 1);
    check("fullpop_count", 64'(Count), 64'd3);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h0, 1);
    check("fullpop_empty", 64'(D_Valid), 64'd0);

    // Reset beats Flush and push/pop
    for (int i = 0; i < 2; i++) drive(0, 0, 1, 32'h7000 + 32'(4 * i), 0);
    drive(1, 1, 1, 32'h7100, 1);
    expect_reset_outputs("rstprio");

    // Wrap: keep two entries in flight while ten entries pass through
    pc = 32'h8000;
    for (int i = 0; i < 2; i++) begin drive(0, 0, 1, pc, 0); pc += 32'd4; end
    for (int i = 0; i < 10; i++) begin drive(0, 0, 1, pc, 1); pc += 32'd4; end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h0, 1);
    check("wrap_empty", 64'(Count), 64'd0);

    // Random traffic
    pc = 32'h9000;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)));
      pc += 32'd4;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter CW, default $clog2(DEPTH)+1, SHALL set the width of Count.
REQ-003 Clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 Flush  input  1  SHALL discard all queued entries on a branch/jump redirect.
REQ-006 F_Valid  input  1  SHALL indicate that the fetch stage presents an instruction.
REQ-007 F_PC  input  32  SHALL carry the fetch address of the presented instruction.
REQ-008 F_Instr  input  32  SHALL carry the fetched instruction word.
REQ-009 F_Ready  output  1  SHALL be high when the queue can accept an entry; the fetch stage drives the PC register enable directly from it.
REQ-010 D_Valid  output  1  SHALL indicate that the queue head is valid for decode.
REQ-011 D_PC  output  32  SHALL carry the PC of the head entry.
REQ-012 D_Instr  output  32  SHALL carry the instruction word of the head entry.
REQ-013 D_Ready  input  1  SHALL indicate that the decode stage consumes the head entry this cycle.
REQ-014 Count  output  CW  SHALL report the current number of occupied entries.

Function
REQ-015 The queue SHALL be a first-word-fall-through FIFO: whenever Count>0, D_PC and D_Instr SHALL show the oldest entry combinationally from registered state.
REQ-016 When Count==0, the outputs SHALL be D_Valid=0, D_Instr=32'h0000_0000 (NOP) and D_PC=32'h0000_0000.
REQ-017 A push SHALL occur on an edge where F_Valid && F_Ready && !Flush; it writes {F_PC, F_Instr} at the tail.
REQ-018 A pop SHALL occur on an edge where D_Valid && D_Ready && !Flush; it advances the head.
REQ-019 F_Ready SHALL equal (Count != DEPTH); it is combinational from state only and independent of D_Ready.
REQ-020 When the queue is full, a simultaneous pop SHALL NOT enable a push in the same cycle; F_Ready stays low for that cycle.
REQ-021 When the queue is empty, a pushed entry SHALL appear at D_* one cycle after the push edge; there is no input-to-output bypass, so the minimum latency is 1 cycle.
REQ-022 A simultaneous push and pop with 0<Count<DEPTH SHALL leave Count unchanged and preserve entry order.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; there is no overflow or underflow under any input sequence.
REQ-024 Flush SHALL set Count=0 and both pointers to 0 on the next edge, ignoring any push or pop requested in the same cycle.
REQ-025 Entry contents SHALL NOT be cleared by Flush; only the valid state is cleared.

Reset
REQ-026 Reset SHALL take priority over Flush and over all push and pop activity.
REQ-027 After a Reset edge: Count=0, head and tail pointers=0, D_Valid=0, D_PC=0, D_Instr=0, F_Ready=1.
REQ-028 A Reset asserted mid-operation SHALL discard all entries within one edge; the first push after deassertion SHALL be the next output.
REQ-029 The storage array SHALL NOT require reset.

Structure
REQ-030 A shared package mips_pkg SHALL hold RESET_PC=32'h0000_3000, NOP_INSTR=32'h0000_0000 and FQ_DEPTH=4.
REQ-031 The block SHALL be a single module with the storage array inline; no sub-module is required.

Verification
REQ-032 Fill test: after Reset, push PCs 0x3000, 0x3004, 0x3008 and 0x300C with D_Ready=0 -> Count=4 and F_Ready=0; a fifth push is not accepted; D_PC=0x3000 throughout.
REQ-033 Drain test: from full, assert D_Ready=1 for 4 cycles -> D_PC sequence 0x3000, 0x3004, 0x3008, 0x300C; then D_Valid=0, D_Instr=0 and F_Ready=1.
REQ-034 Streaming test: hold F_Valid=1 and D_Ready=1 continuously from empty -> Count settles at 1 and D_PC increments by 4 every cycle, with a first-output latency of 1 cycle.
REQ-035 Flush test: with Count=3, assert Flush together with F_Valid and D_Ready -> next cycle Count=0 and D_Valid=0; the flushed-cycle push does not appear.
REQ-036 Full-pop test: with Count=4, assert F_Valid=1 and D_Ready=1 -> Count=3 and the new entry is not written.
REQ-037 Reset-priority and wrap test: assert Reset and Flush together with Count=2 -> all outputs take their reset values; then push 10 entries while popping -> pointers wrap and entry order is preserved.
